spi_flash_responder: RTL and testbench

SPI target that answers the command frames issued by the APB-to-SPI flash controller: it decodes a 32-bit header (24-bit address plus 8-bit opcode) and then either returns or stores 32-bit data words held in an internal register-file memory. The block sits on the far side of the SPI link and serves as the flash-side model or soft target. It oversamples the SPI pins with the system clock, so it has a single clock domain.

---
 rtl/spi_flash_pkg.sv | 19 +
 rtl/spi_pin_sync.sv | 32 +++
 rtl/spi_flash_responder.sv | 143 ++++++++++++++
 tb/tb_spi_flash_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash link: opcodes, frame sizes and the
// responder state encoding.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam int HDR_BITS  = 32;
    localparam int WORD_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_WR,
        ST_SINK
    } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for one SPI pin, followed by a history flop that
// yields single-cycle rise/fall strobes on the synchronised level.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Reset to the pin's idle level so that leaving reset creates no false edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {2{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            prev_q <= sync_q[1];
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~prev_q;
    assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash-side target: decodes a 32-bit {addr, opcode} header and
// then serves burst reads or burst writes from an internal word memory.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic p_clk,
    input  logic p_rst,
    input  logic s_clk,
    input  logic s_css,
    input  logic s_mosi,
    output logic s_miso,
    output logic busy,
    output logic err
);

    localparam logic [4:0] HDR_LAST  = 5'(HDR_BITS - 1);
    localparam logic [4:0] WORD_LAST = 5'(WORD_BITS - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic css_lvl, css_rise, css_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk_i(p_clk), .rst_i(p_rst), .pin_i(s_clk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b1)) u_sync_css (
        .clk_i(p_clk), .rst_i(p_rst), .pin_i(s_css),
        .level_o(css_lvl), .rise_o(css_rise), .fall_o(css_fall)
    );
    spi_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(p_clk), .rst_i(p_rst), .pin_i(s_mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    logic unused_pin_info;
    assign unused_pin_info = ^{sclk_lvl, css_lvl, mosi_rise, mosi_fall};

    state_e          state_q;
    logic [4:0]      bcnt_q;
    logic [31:0]     hdr_q, rx_q, tx_q;
    logic [AW-1:0]   addr_q;
    logic            miso_q, err_q;
    logic [31:0]     mem_q [DEPTH];

    logic [31:0]     hdr_d, rx_d;
    logic [AW-1:0]   hdr_addr, addr_inc;
    logic            last_bit, word_done;

    assign hdr_d     = {hdr_q[30:0], mosi_lvl};
    assign rx_d      = {rx_q[30:0], mosi_lvl};
    assign hdr_addr  = hdr_d[AW+7:8];
    assign addr_inc  = addr_q + AW'(1);
    assign last_bit  = (state_q == ST_HDR) ? (bcnt_q == HDR_LAST) : (bcnt_q == WORD_LAST);
    assign word_done = sclk_rise && last_bit &&
                       (state_q == ST_HDR || state_q == ST_RD || state_q == ST_WR);

    always_ff @(posedge p_clk or posedge p_rst) begin
        if (p_rst) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            hdr_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            addr_q  <= '0;
            miso_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            err_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                miso_q <= 1'b0;
                if (css_fall) begin
                    state_q <= ST_HDR;
                    bcnt_q  <= '0;
                end
            end else if (css_rise) begin
                // A deselect landing on the final bit still completes that word.
                if (word_done && state_q == ST_WR) begin
                    mem_q[addr_q] <= rx_d;
                    addr_q        <= addr_inc;
                end
                err_q   <= !word_done && (bcnt_q != 5'd0);
                state_q <= ST_IDLE;
                miso_q  <= 1'b0;
                bcnt_q  <= '0;
            end else begin
                case (state_q)
                    ST_HDR: if (sclk_rise) begin
                        hdr_q  <= hdr_d;
                        bcnt_q <= bcnt_q + 5'd1;
                        if (bcnt_q == HDR_LAST) begin
                            addr_q <= hdr_addr;
                            case (hdr_d[7:0])
                                OP_READ: begin
                                    state_q <= ST_RD;
                                    tx_q    <= mem_q[hdr_addr];
                                    miso_q  <= mem_q[hdr_addr][31];
                                end
                                OP_WRITE: state_q <= ST_WR;
                                default: begin
                                    state_q <= ST_SINK;
                                    err_q   <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_RD: begin
                        // The falling edge right after a load keeps the fresh MSB in place.
                        if (sclk_rise) begin
                            bcnt_q <= bcnt_q + 5'd1;
                            if (bcnt_q == WORD_LAST) begin
                                addr_q <= addr_inc;
                                tx_q   <= mem_q[addr_inc];
                                miso_q <= mem_q[addr_inc][31];
                            end
                        end else if (sclk_fall && bcnt_q != 5'd0) begin
                            tx_q   <= {tx_q[30:0], 1'b0};
                            miso_q <= tx_q[30];
                        end
                    end
                    ST_WR: if (sclk_rise) begin
                        rx_q   <= rx_d;
                        bcnt_q <= bcnt_q + 5'd1;
                        if (bcnt_q == WORD_LAST) begin
                            mem_q[addr_q] <= rx_d;
                            addr_q        <= addr_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_miso = miso_q;
    assign busy   = (state_q != ST_IDLE);
    assign err    = err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: an SPI mode-0 initiator driven from one
// directed sequence, checked against a plain word-array memory model.
module tb_spi_flash_responder;

    localparam int HALF = 6;

    logic p_clk = 1'b0;
    logic p_rst = 1'b1;
    logic s_clk = 1'b0;
    logic s_css = 1'b1;
    logic s_mosi = 1'b0;
    logic s_miso, busy, err;

    always #5 p_clk = ~p_clk;

    spi_flash_responder #(.DEPTH(16), .AW(4)) dut (
        .p_clk(p_clk), .p_rst(p_rst), .s_clk(s_clk), .s_css(s_css),
        .s_mosi(s_mosi), .s_miso(s_miso), .busy(busy), .err(err)
    );

    int total = 0;
    int bad   = 0;
    int err_hi = 0;
    int err_pulses = 0;
    logic err_prev = 1'b0;

    logic [31:0] ref_mem [16];
    logic [31:0] buf_w [4];

    always @(negedge p_clk) begin
        if (err) err_hi <= err_hi + 1;
        if (err && !err_prev) err_pulses <= err_pulses + 1;
        err_prev <= err;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic bit_x(input logic b, output logic r);
        s_mosi = b;
        repeat (HALF) @(negedge p_clk);
        r = s_miso;
        s_clk = 1'b1;
        repeat (HALF) @(negedge p_clk);
        s_clk = 1'b0;
    endtask

    task automatic word_x(input logic [31:0] tx, output logic [31:0] rx);
        logic b;
        for (int i = 31; i >= 0; i--) begin
            bit_x(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic begin_frame();
        s_css = 1'b0;
        repeat (8) @(negedge p_clk);
    endtask

    task automatic end_frame();
        repeat (HALF) @(negedge p_clk);
        s_css = 1'b1;
        repeat (8) @(negedge p_clk);
    endtask

    task automatic send_hdr(input int a, input logic [7:0] op);
        logic [31:0] dummy;
        word_x({a[23:0], op}, dummy);
    endtask

    task automatic wr_frame(input int a, input int n);
        logic [31:0] dummy;
        begin_frame();
        send_hdr(a, 8'h02);
        for (int i = 0; i < n; i++) begin
            word_x(buf_w[i], dummy);
            ref_mem[(a + i) % 16] = buf_w[i];
        end
        end_frame();
    endtask

    task automatic rd_check(input string tag, input int a, input int n);
        logic [31:0] r;
        begin_frame();
        send_hdr(a, 8'h01);
        for (int i = 0; i < n; i++) begin
            word_x(32'h0, r);
            check($sformatf("%s[%0d]", tag, i), r, ref_mem[(a + i) % 16]);
        end
        end_frame();
    endtask

    initial begin
        int e0, h0, a, n;
        logic b, acc;

        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        @(negedge p_clk);
        repeat (3) @(negedge p_clk);
        check("rst_miso", 32'(s_miso), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        p_rst = 1'b0;
        repeat (5) @(negedge p_clk);
        check("idle_miso", 32'(s_miso), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);

        rd_check("rd3_zero", 3, 1);

        begin_frame();
        check("busy_in_frame", 32'(busy), 32'h1);
        end_frame();
        check("busy_after_frame", 32'(busy), 32'h0);

        buf_w[0] = 32'hDEAD_BEEF;
        wr_frame(5, 1);
        rd_check("rd5", 5, 1);

        buf_w[0] = 32'h1111_1111;
        buf_w[1] = 32'h2222_2222;
        wr_frame(15, 2);
        rd_check("burst_wrap", 15, 2);
        rd_check("rd0_wrapped", 0, 1);

        e0 = err_pulses;
        h0 = err_hi;
        begin_frame();
        send_hdr(5, 8'hA5);
        acc = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bit_x(1'($urandom_range(0, 1)), b);
            acc = acc | b;
        end
        end_frame();
        check("sink_miso", 32'(acc), 32'h0);
        check("badop_err_pulses", 32'(err_pulses - e0), 32'h1);
        check("badop_err_width", 32'(err_hi - h0), 32'h1);
        rd_check("badop_rd5", 5, 1);
        rd_check("badop_rd15", 15, 1);

        buf_w[0] = 32'hCAFE_F00D;
        wr_frame(2, 1);
        e0 = err_pulses;
        begin_frame();
        send_hdr(2, 8'h02);
        for (int i = 0; i < 20; i++) bit_x(1'($urandom_range(0, 1)), b);
        end_frame();
        check("abort_err", 32'(err_pulses - e0), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        rd_check("abort_rd2", 2, 1);

        e0 = err_pulses;
        for (int k = 0; k < 6; k++) begin
            a = $urandom_range(0, 15);
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) buf_w[i] = $urandom;
            wr_frame(a, n);
            rd_check($sformatf("rnd%0d", k), a, n);
            rd_check($sformatf("rnd%0d_any", k), $urandom_range(0, 15), 2);
        end
        check("rnd_no_err", 32'(err_pulses - e0), 32'h0);

        buf_w[0] = 32'h8765_4321;
        wr_frame(7, 1);
        begin_frame();
        send_hdr(7, 8'h01);
        for (int i = 0; i < 10; i++) bit_x(1'b0, b);
        p_rst = 1'b1;
        repeat (2) @(negedge p_clk);
        check("midrst_miso", 32'(s_miso), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        s_css = 1'b1;
        s_clk = 1'b0;
        repeat (2) @(negedge p_clk);
        p_rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        repeat (8) @(negedge p_clk);
        rd_check("postrst_rd7", 7, 1);
        buf_w[0] = $urandom;
        buf_w[1] = $urandom;
        wr_frame(9, 2);
        rd_check("postrst_rd9", 9, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
